// File: rtl/flag_check_pkg.sv
// Shared definitions for the sequential flag checker: FSM states, default
// geometry and a small helper for sizing index fields.
package flag_check_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_NUM_WORDS = 8;

  // Checker control states. RUN accepts words, DONE holds the verdict.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a word index. A single-word flag still needs one bit so that
  // the index and first_bad ports never collapse to zero width.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter able to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/flag_word_diff.sv
// Per-word syndrome: un-masks one received word with the mask key word and
// compares it against the expected word. A zero diff means the word is right.
module flag_word_diff
  import flag_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] mask_word,
  input  logic [WIDTH-1:0] check_word,
  output logic [WIDTH-1:0] diff,
  output logic             nonzero
);

  // Syndrome bits are set exactly where the un-masked word differs from the key.
  always_comb begin
    diff    = (in_data ^ mask_word) ^ check_word;
    nonzero = |diff;
  end

endmodule

// File: rtl/seq_flag_checker.sv
// Sequential flag checker: accepts a flag one word at a time, builds a
// per-bit syndrome against a masked key, counts bad words, remembers the
// first bad one and reports a pass/fail verdict once the flag has ended.
module seq_flag_checker
  import flag_check_pkg::*;
#(
  parameter int                                WIDTH     = DEFAULT_WIDTH,
  parameter int                                NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter logic [WIDTH*NUM_WORDS-1:0]        MASK_KEY  = '0,
  parameter logic [WIDTH*NUM_WORDS-1:0]        CHECK_KEY = '0,
  localparam int                               IDXW      = index_width(NUM_WORDS),
  localparam int                               CNTW      = count_width(NUM_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       done,
  output logic                       pass,
  output logic                       len_err,
  output logic [CNTW-1:0]            mismatch_cnt,
  output logic [IDXW-1:0]            first_bad,
  output logic [WIDTH*NUM_WORDS-1:0] wrong
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  mask_word;
  logic [WIDTH-1:0]  check_word;
  logic [WIDTH-1:0]  diff;
  logic              nonzero;
  logic              xfer;
  logic              at_last;
  logic              ending;
  logic              start_accept;

  // Key words for the slot currently being filled are picked by the word index.
  always_comb begin
    mask_word  = MASK_KEY[idx*WIDTH +: WIDTH];
    check_word = CHECK_KEY[idx*WIDTH +: WIDTH];
  end

  flag_word_diff #(
    .WIDTH(WIDTH)
  ) u_word_diff (
    .in_data    (in_data),
    .mask_word  (mask_word),
    .check_word (check_word),
    .diff       (diff),
    .nonzero    (nonzero)
  );

  // Handshake decode: a start only counts outside RUN, and a flag ends either
  // on its final slot or on an early in_last from the sender.
  always_comb begin
    xfer         = in_valid && in_ready;
    at_last      = (idx == LAST_IDX);
    ending       = xfer && (at_last || in_last);
    start_accept = start && (state != RUN);
  end

  // State register; reset wins over everything else on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the state-decoded handshake and verdict outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (ending) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        pass = (mismatch_cnt == '0) && !len_err;
        if (start) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Result datapath: cleared by reset or an accepted start, otherwise updated
  // only on a transfer so stalls and the DONE state leave results untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      wrong        <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      len_err      <= 1'b0;
    end else if (start_accept) begin
      idx          <= '0;
      wrong        <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      len_err      <= 1'b0;
    end else if (xfer) begin
      wrong[idx*WIDTH +: WIDTH] <= diff;
      if (nonzero) begin
        mismatch_cnt <= mismatch_cnt + CNTW'(1);
        if (mismatch_cnt == '0) begin
          first_bad <= idx;
        end
      end
      if (in_last && !at_last) begin
        len_err <= 1'b1;
      end
      if (!ending) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_flag_checker.sv
// Directed testbench for seq_flag_checker with a 4 x 8-bit flag.
module tb_seq_flag_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        done;
  logic        pass;
  logic        len_err;
  logic [2:0]  mismatch_cnt;
  logic [1:0]  first_bad;
  logic [31:0] wrong;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [31:0] words;
    int          n;
    bit          use_last;
    int          gap;
    bit          exp_pass;
    bit          exp_len;
    int          exp_cnt;
    int          exp_fb;
    logic [31:0] exp_wrong;
  } vec_t;

  vec_t vecs[8];

  seq_flag_checker #(
    .WIDTH     (8),
    .NUM_WORDS (4),
    .MASK_KEY  (32'h11223344),
    .CHECK_KEY (32'h78414A3F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .done         (done),
    .pass         (pass),
    .len_err      (len_err),
    .mismatch_cnt (mismatch_cnt),
    .first_bad    (first_bad),
    .wrong        (wrong)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(string name, logic [31:0] words, int n, bit use_last,
                                   int gap, bit exp_pass, bit exp_len, int exp_cnt,
                                   int exp_fb, logic [31:0] exp_wrong);
    vec_t v;
    v.name      = name;
    v.words     = words;
    v.n         = n;
    v.use_last  = use_last;
    v.gap       = gap;
    v.exp_pass  = exp_pass;
    v.exp_len   = exp_len;
    v.exp_cnt   = exp_cnt;
    v.exp_fb    = exp_fb;
    v.exp_wrong = exp_wrong;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Verdict and results once a flag has ended (sampled 1 time unit after the edge).
  task automatic checkResult(input vec_t v, input string tag);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
    checkOutput({tag, " len_err"}, 32'(len_err), 32'(v.exp_len));
    checkOutput({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(v.exp_cnt));
    if (v.exp_cnt != 0) begin
      checkOutput({tag, " first_bad"}, 32'(first_bad), 32'(v.exp_fb));
    end
    checkOutput({tag, " wrong"}, wrong, v.exp_wrong);
  endtask

  // Start a check, then send n words with optional gaps; optionally pulse
  // start during the gap before word 2 (must be ignored while running).
  task automatic applyStimulus(input vec_t v, input bit start_in_gap, input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, " cleared cnt"}, 32'(mismatch_cnt), 32'd0);
    checkOutput({tag, " cleared len_err"}, 32'(len_err), 32'd0);
    checkOutput({tag, " cleared wrong"}, wrong, 32'd0);
    checkOutput({tag, " run done"}, 32'(done), 32'd0);
    for (int i = 0; i < v.n; i++) begin
      for (int g = 0; g < v.gap; g++) begin
        in_valid = 1'b0;
        start    = start_in_gap && (i == 2);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, " stall in_ready"}, 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_data  = v.words[i*8 +: 8];
      in_last  = v.use_last && (i == v.n - 1);
      checkOutput({tag, " pre done"}, 32'(done), 32'd0);
      checkOutput({tag, " pre in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  // One full check plus a hold cycle where offered data must be refused.
  task automatic runVec(input vec_t v, input bit start_in_gap, input string tag);
    applyStimulus(v, start_in_gap, tag);
    checkResult(v, tag);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    checkOutput({tag, " hold done"}, 32'(done), 32'd1);
    checkOutput({tag, " hold cnt"}, 32'(mismatch_cnt), 32'(v.exp_cnt));
    checkOutput({tag, " hold wrong"}, wrong, v.exp_wrong);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass), 32'd0);
    checkOutput({tag, " len_err"}, 32'(len_err), 32'd0);
    checkOutput({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
    checkOutput({tag, " first_bad"}, 32'(first_bad), 32'd0);
    checkOutput({tag, " wrong"}, wrong, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    // Correct flag is 7B,79,63,69 (word 0 in the low byte).
    vecs[0] = makeVec("good",       32'h6963797B, 4, 1'b0, 0, 1'b1, 1'b0, 0, 0, 32'h00000000);
    vecs[1] = makeVec("bad_w2",     32'h6962797B, 4, 1'b0, 0, 1'b0, 1'b0, 1, 2, 32'h00010000);
    vecs[2] = makeVec("good_again", 32'h6963797B, 4, 1'b0, 0, 1'b1, 1'b0, 0, 0, 32'h00000000);
    vecs[3] = makeVec("short_w1",   32'h0000797B, 2, 1'b1, 0, 1'b0, 1'b1, 0, 0, 32'h00000000);
    vecs[4] = makeVec("multi_bad",  32'h00007900, 4, 1'b0, 1, 1'b0, 1'b0, 3, 0, 32'h6963007B);
    vecs[5] = makeVec("last_on_w3", 32'h6963797B, 4, 1'b1, 1, 1'b1, 1'b0, 0, 0, 32'h00000000);
    vecs[6] = makeVec("short_w0",   32'h000000FF, 1, 1'b1, 0, 1'b0, 1'b1, 1, 0, 32'h00000084);
    vecs[7] = makeVec("bad_w3",     32'h6863797B, 4, 1'b0, 0, 1'b0, 1'b0, 1, 3, 32'h01000000);

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle in_ready", 32'(in_ready), 32'd0);

    for (int k = 0; k < 8; k++) begin
      runVec(vecs[k], 1'b0, vecs[k].name);
    end

    // Stalls of three cycles per word with start pulsed mid-run.
    vecs[0].gap = 3;
    runVec(vecs[0], 1'b1, "gaps_start");
    vecs[0].gap = 0;

    // Reset lands on an edge carrying a transfer and a start.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h7B;
    @(posedge clk); #1;
    in_data  = 8'h70;
    @(posedge clk); #1;
    checkOutput("pre_rst cnt", 32'(mismatch_cnt), 32'd1);
    in_data = 8'h63;
    start   = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    checkAllZero("mid_rst");
    @(posedge clk); #1;
    checkOutput("post_rst idle", 32'(in_ready), 32'd0);
    runVec(vecs[0], 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_flag_checker.md
SEQ_FLAG_CHECKER -- requirements
Module: seq_flag_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per input word.
REQ-002 SHALL have parameter NUM_WORDS, default 8: words per flag; word k occupies bits [k*WIDTH +: WIDTH] of every key and syndrome.
REQ-003 SHALL have parameter MASK_KEY, default all-zero, width WIDTH*NUM_WORDS: first-stage XOR key.
REQ-004 SHALL have parameter CHECK_KEY, default all-zero, width WIDTH*NUM_WORDS: expected masked value.
REQ-005 SHALL use a single clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: begin/restart a check.
REQ-009 SHALL have port in_valid, input, 1: in_data valid.
REQ-010 SHALL have port in_ready, output, 1: block accepts a word.
REQ-011 SHALL have port in_data, input, WIDTH: flag word.
REQ-012 SHALL have port in_last, input, 1: sender's final word.
REQ-013 SHALL have port done, output, 1: result valid.
REQ-014 SHALL have port pass, output, 1: flag correct.
REQ-015 SHALL have port len_err, output, 1: in_last arrived early.
REQ-016 SHALL have port mismatch_cnt, output, $clog2(NUM_WORDS+1): number of bad words.
REQ-017 SHALL have port first_bad, output, $clog2(NUM_WORDS) (min 1): index of lowest bad word.
REQ-018 SHALL have port wrong, output, WIDTH*NUM_WORDS: per-bit syndrome.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DONE.
REQ-020 SHALL move IDLE->RUN and DONE->RUN on start, clearing wrong, mismatch_cnt, first_bad, len_err and the word index in the same edge.
REQ-021 SHALL ignore start while in RUN.
REQ-022 SHALL drive in_ready=1 only in RUN; a transfer is in_valid && in_ready on a rising edge.
REQ-023 SHALL compute, for the transfer at index k, diff = (in_data ^ MASK_KEY word k) ^ CHECK_KEY word k, and register it into wrong word k on that edge.
REQ-024 SHALL, on any transfer with diff != 0, increment mismatch_cnt, and load first_bad=k if mismatch_cnt was 0.
REQ-025 SHALL increment the word index per transfer and enter DONE after the transfer at index NUM_WORDS-1, with or without in_last.
REQ-026 SHALL, on in_last with index < NUM_WORDS-1, set len_err=1 and enter DONE; untransferred syndrome words remain 0.
REQ-027 SHALL assert done the cycle after the ending transfer and hold it, with all results stable, for the whole DONE state.
REQ-028 SHALL drive pass = done && (mismatch_cnt == 0) && !len_err.
REQ-029 SHALL hold in_ready=0, done=0 and pass=0 in IDLE and RUN; first_bad is meaningful only when mismatch_cnt != 0.
REQ-030 SHALL stall without side effects while in_valid=0 in RUN, for any number of cycles.

Reset
REQ-031 SHALL, on an edge with rst=1 in any state, mid-transfer included, enter IDLE with in_ready, done, pass, len_err, mismatch_cnt, first_bad, wrong and word index all 0.
REQ-032 SHALL give rst priority over start and over a simultaneous transfer.

Structure
REQ-033 SHALL place the state enum and the default WIDTH/NUM_WORDS in shared package flag_check_pkg.
REQ-034 SHALL use one combinational sub-module flag_word_diff (in_data, mask word, check word -> diff, nonzero flag), instantiated once and driven from the word index.

Verification (WIDTH=8, NUM_WORDS=4, MASK_KEY=32'h11223344, CHECK_KEY=32'h78414A3F; word 0 first)
REQ-035 SHALL cover: start, words 7B,79,63,69 back-to-back -> done 1 cycle after 4th transfer, pass=1, mismatch_cnt=0, wrong=0.
REQ-036 SHALL cover: word 2 sent as 62 -> pass=0, mismatch_cnt=1, first_bad=2, wrong=32'h00010000.
REQ-037 SHALL cover: in_last on word 1 (7B,79) -> done, len_err=1, pass=0, wrong=0.
REQ-038 SHALL cover: 3-cycle in_valid gaps plus start pulsed in RUN -> result identical to REQ-035.
REQ-039 SHALL cover: rst after 2 transfers -> all outputs 0 next edge; new start and correct flag -> pass=1.
REQ-040 SHALL cover: start in DONE after a failing run -> results cleared, correct flag -> pass=1, mismatch_cnt=0.
